// File: rtl/draw_ball_pkg.sv
// Shared constants and types for the draw stages: screen geometry, sprite
// defaults, the timing bundle passed between stages, and a span-compare helper.
package draw_ball_pkg;

    localparam logic [10:0] SCREEN_W      = 11'd1024;
    localparam logic [10:0] SCREEN_H      = 11'd768;
    localparam int          BALL_W_DEF    = 64;
    localparam int          BALL_H_DEF    = 64;
    localparam logic [11:0] KEY_COLOR_DEF = 12'hF0F;

    // Timing bundle as it travels down the pipeline, MSB first.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
    } timing_t;

    localparam int TIMING_W  = $bits(timing_t);
    localparam int DELAY_W   = TIMING_W + 1;
    localparam int DELAY_CLK = 2;

    // 12-bit sums so a start near 2047 cannot wrap into a false hit.
    function automatic logic in_span(input logic [10:0] pos,
                                     input logic [10:0] start,
                                     input logic [11:0] size);
        logic [11:0] stop;
        stop = {1'b0, start} + size;
        return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} < stop);
    endfunction

endpackage

// File: rtl/draw_ball_delay.sv
// Generic register delay line: dout follows din by CLK_DEL clocks, cleared by
// an asynchronous active-low reset.
module draw_ball_delay #(
    parameter int WIDTH   = 27,
    parameter int CLK_DEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [CLK_DEL-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_ball.sv
// Ball sprite overlay stage: composites a keyed sprite from an external
// 1-cycle ROM over the background, with a fixed 3-clock pipeline.
module draw_ball
    import draw_ball_pkg::*;
#(
    parameter int          BALL_W    = BALL_W_DEF,
    parameter int          BALL_H    = BALL_H_DEF,
    parameter logic [11:0] KEY_COLOR = KEY_COLOR_DEF
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    input  logic [11:0] rgb_pixel,
    output logic [$clog2(BALL_W)+$clog2(BALL_H)-1:0] rom_addr,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int XW = $clog2(BALL_W);
    localparam int YW = $clog2(BALL_H);

    logic [10:0]        x_lat;
    logic [10:0]        y_lat;
    logic               vblnk_prev;
    logic               hit;
    logic [XW-1:0]      col;
    logic [YW-1:0]      row;
    logic [11:0]        rgb_s1;
    logic [11:0]        rgb_s2;
    timing_t            timing_in;
    timing_t            timing_d2;
    logic               hit_d2;
    logic [DELAY_W-1:0] dly_in;
    logic [DELAY_W-1:0] dly_out;

    // Position is sampled once per frame so the ball never tears mid-frame.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            x_lat      <= '0;
            y_lat      <= '0;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    assign hit = in_span(hcount_in, x_lat, 12'(BALL_W)) &&
                 in_span(vcount_in, y_lat, 12'(BALL_H));

    assign col = hcount_in[XW-1:0] - x_lat[XW-1:0];
    assign row = vcount_in[YW-1:0] - y_lat[YW-1:0];

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            rom_addr <= '0;
        end else if (hit) begin
            rom_addr <= {row, col};
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            rgb_s1 <= '0;
            rgb_s2 <= '0;
        end else begin
            rgb_s1 <= rgb_in;
            rgb_s2 <= rgb_s1;
        end
    end

    // The hit flag rides in the spare top bit of the timing delay line, so it
    // is registered alongside rom_addr and lines up with rgb_pixel.
    assign timing_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};
    assign dly_in    = {hit, timing_in};

    draw_ball_delay #(
        .WIDTH   (DELAY_W),
        .CLK_DEL (DELAY_CLK)
    ) u_timing_delay (
        .clk  (pclk),
        .rst  (rst),
        .din  (dly_in),
        .dout (dly_out)
    );

    assign hit_d2    = dly_out[DELAY_W-1];
    assign timing_d2 = dly_out[TIMING_W-1:0];

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= timing_d2.hcount;
            vcount_out <= timing_d2.vcount;
            hsync_out  <= timing_d2.hsync;
            hblnk_out  <= timing_d2.hblnk;
            vsync_out  <= timing_d2.vsync;
            vblnk_out  <= timing_d2.vblnk;
            if (hit_d2 && (rgb_pixel != KEY_COLOR) && !timing_d2.hblnk && !timing_d2.vblnk) begin
                rgb_out <= rgb_pixel;
            end else begin
                rgb_out <= rgb_s2;
            end
        end
    end

endmodule
